// File: rtl/ri_pkg.sv
// Shared types and elaboration helpers for the RI pad data-path sequencer.
package ri_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WPRE,
    ST_WDATA,
    ST_WPOST,
    ST_RWAIT,
    ST_RCAP
  } ri_state_e;

  function automatic bit bl_legal(int bl);
    return (bl == 2) || (bl == 4) || (bl == 8);
  endfunction

  function automatic bit cfg_legal(int dw, int bl);
    return ((dw % 8) == 0) && bl_legal(bl);
  endfunction

  function automatic int lanes(int dw);
    return dw / 8;
  endfunction

  function automatic int beat_w(int bl);
    return $clog2(bl);
  endfunction

endpackage

// File: rtl/ri_dq_seq_if.sv
// Controller-side and pad-side signal bundle of ri_dq_seq.
interface ri_dq_seq_if #(
  parameter int DW  = 32,
  parameter int BL  = 4,
  parameter int CLW = 3
);
  import ri_pkg::*;
  localparam int LANES = lanes(DW);

  logic [CLW-1:0]      cas_lat;
  logic                cmd_valid;
  logic                cmd_write;
  logic                cmd_ready;
  logic [BL*DW-1:0]    mdout;
  logic [BL*LANES-1:0] mdqm;
  logic [BL*DW-1:0]    mdin;
  logic                mdin_valid;
  logic [DW-1:0]       dq_out;
  logic [LANES-1:0]    dq_oe;
  logic [DW-1:0]       dq_in;
  logic [LANES-1:0]    dqm_out;
  logic                strobe_out;
  logic                strobe_oe;

  modport slave (
    input  cas_lat, cmd_valid, cmd_write, mdout, mdqm, dq_in,
    output cmd_ready, mdin, mdin_valid, dq_out, dq_oe, dqm_out, strobe_out, strobe_oe
  );

  modport master (
    output cas_lat, cmd_valid, cmd_write, mdout, mdqm, dq_in,
    input  cmd_ready, mdin, mdin_valid, dq_out, dq_oe, dqm_out, strobe_out, strobe_oe
  );
endinterface

// File: rtl/ri_burst_shift.sv
// BL x W burst register: parallel load, or shift one W-bit slice toward the MSB end.
module ri_burst_shift #(
  parameter int BL = 4,
  parameter int W  = 32
) (
  input  logic          clk,
  input  logic          i_load,
  input  logic          i_shift,
  input  logic [BL*W-1:0] i_d,
  input  logic [W-1:0]  i_sin,
  output logic [BL*W-1:0] o_q
);
  logic [BL*W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_load)       r_q <= i_d;
    else if (i_shift) r_q <= {r_q[(BL-1)*W-1:0], i_sin};
  end

  assign o_q = r_q;
endmodule

// File: rtl/ri_dq_seq.sv
// Write-burst serialiser and read-burst capture between the RI controller and DDR pad cells.
module ri_dq_seq
  import ri_pkg::*;
#(
  parameter int DW  = 32,
  parameter int BL  = 4,
  parameter int CLW = 3
) (
  input logic         memclk,
  input logic         reset_l,
  ri_dq_seq_if.slave  bus
);
  localparam int LANES = lanes(DW);
  localparam int BW    = beat_w(BL);

  if (!cfg_legal(DW, BL)) begin : g_bad_cfg
    $error("ri_dq_seq: DW must be a multiple of 8 and BL one of 2, 4, 8");
  end

  ri_state_e           r_state, w_nxt_state;
  logic [BW-1:0]       r_beat, w_wbeat_n;
  logic [CLW-1:0]      r_lat, w_lat_ld;
  logic                w_accept, w_last, w_wshift, w_cshift;
  logic [BL*DW-1:0]    w_wd_q, w_cap_q;
  logic [BL*LANES-1:0] w_wm_q;
  logic                w_unused;

  logic [DW-1:0]       w_dq_out_n, r_dq_out;
  logic [LANES-1:0]    w_dqm_n, r_dqm_out, w_dq_oe_n, r_dq_oe;
  logic                w_strobe_out_n, r_strobe_out, w_strobe_oe_n, r_strobe_oe;
  logic                w_cmd_ready_n, r_cmd_ready, w_mdin_valid_n, r_mdin_valid;
  logic [BL*DW-1:0]    r_mdin;

  assign w_accept = bus.cmd_valid & r_cmd_ready;
  assign w_last   = (r_beat == BW'(BL - 1));
  assign w_wshift = (r_state == ST_WPRE) | ((r_state == ST_WDATA) & ~w_last);
  assign w_cshift = (r_state == ST_RCAP);
  // Cycles spent in RWAIT: one less than the effective latency (minimum 2).
  assign w_lat_ld = (bus.cas_lat < CLW'(2)) ? CLW'(1) : bus.cas_lat - CLW'(1);
  assign w_unused = ^{w_wd_q[(BL-1)*DW-1:0], w_wm_q[(BL-1)*LANES-1:0], w_cap_q[BL*DW-1 -: DW]};

  ri_burst_shift #(.BL(BL), .W(DW)) u_wdata (
    .clk(memclk), .i_load(w_accept & bus.cmd_write), .i_shift(w_wshift),
    .i_d(bus.mdout), .i_sin('0), .o_q(w_wd_q)
  );

  ri_burst_shift #(.BL(BL), .W(LANES)) u_wmask (
    .clk(memclk), .i_load(w_accept & bus.cmd_write), .i_shift(w_wshift),
    .i_d(bus.mdqm), .i_sin('0), .o_q(w_wm_q)
  );

  ri_burst_shift #(.BL(BL), .W(DW)) u_rcap (
    .clk(memclk), .i_load(1'b0), .i_shift(w_cshift),
    .i_d('0), .i_sin(bus.dq_in), .o_q(w_cap_q)
  );

  always_ff @(posedge memclk) begin
    if (!reset_l) r_state <= ST_IDLE;
    else          r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_nxt_state = bus.cmd_write ? ST_WPRE : ST_RWAIT;
      ST_WPRE:  w_nxt_state = ST_WDATA;
      ST_WDATA: if (w_last) w_nxt_state = ST_WPOST;
      ST_WPOST: w_nxt_state = ST_IDLE;
      ST_RWAIT: if (r_lat == CLW'(1)) w_nxt_state = ST_RCAP;
      ST_RCAP:  if (w_last) w_nxt_state = ST_IDLE;
      default:  w_nxt_state = ST_IDLE;
    endcase
  end

  // Next values of the registered pad/controller outputs.
  always_comb begin
    w_wbeat_n      = (r_state == ST_WPRE) ? '0 : r_beat + 1'b1;
    w_dq_out_n     = w_wshift ? w_wd_q[BL*DW-1 -: DW] : '0;
    w_dqm_n        = w_wshift ? w_wm_q[BL*LANES-1 -: LANES] : '0;
    w_dq_oe_n      = w_wshift ? {LANES{1'b1}} : '0;
    w_strobe_out_n = w_wshift & ~w_wbeat_n[0];
    w_strobe_oe_n  = (w_nxt_state == ST_WPRE) | (w_nxt_state == ST_WDATA) |
                     (w_nxt_state == ST_WPOST);
    w_cmd_ready_n  = (w_nxt_state == ST_IDLE);
    w_mdin_valid_n = (r_state == ST_RCAP) & w_last;
  end

  always_ff @(posedge memclk) begin
    if (!reset_l) begin
      r_beat       <= '0;
      r_lat        <= '0;
      r_dq_out     <= '0;
      r_dqm_out    <= '0;
      r_dq_oe      <= '0;
      r_strobe_out <= 1'b0;
      r_strobe_oe  <= 1'b0;
      r_cmd_ready  <= 1'b1;
      r_mdin_valid <= 1'b0;
      r_mdin       <= '0;
    end else begin
      if ((r_state == ST_WDATA) || (r_state == ST_RCAP))
        r_beat <= w_last ? '0 : r_beat + 1'b1;
      else
        r_beat <= '0;
      if (w_accept)                 r_lat <= w_lat_ld;
      else if (r_state == ST_RWAIT) r_lat <= r_lat - 1'b1;
      r_dq_out     <= w_dq_out_n;
      r_dqm_out    <= w_dqm_n;
      r_dq_oe      <= w_dq_oe_n;
      r_strobe_out <= w_strobe_out_n;
      r_strobe_oe  <= w_strobe_oe_n;
      r_cmd_ready  <= w_cmd_ready_n;
      r_mdin_valid <= w_mdin_valid_n;
      // The final beat joins the already-shifted earlier beats directly.
      if (w_mdin_valid_n) r_mdin <= {w_cap_q[(BL-1)*DW-1:0], bus.dq_in};
    end
  end

  assign bus.dq_out     = r_dq_out;
  assign bus.dqm_out    = r_dqm_out;
  assign bus.dq_oe      = r_dq_oe;
  assign bus.strobe_out = r_strobe_out;
  assign bus.strobe_oe  = r_strobe_oe;
  assign bus.cmd_ready  = r_cmd_ready;
  assign bus.mdin_valid = r_mdin_valid;
  assign bus.mdin       = r_mdin;
endmodule

// File: tb/tb_ri_dq_seq.sv
// Directed bench for ri_dq_seq: reset, write/read bursts, back-to-back, reset mid-read, BL/DW sweep.
module tb_ri_dq_seq;
  logic clk = 1'b0;
  logic reset_l = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ri_dq_seq_if #(.DW(32), .BL(4), .CLW(3)) bus ();
  ri_dq_seq_if #(.DW(64), .BL(8), .CLW(3)) bus64 ();
  ri_dq_seq_if #(.DW(32), .BL(2), .CLW(3)) bus2 ();

  ri_dq_seq #(.DW(32), .BL(4), .CLW(3)) dut   (.memclk(clk), .reset_l(reset_l), .bus(bus.slave));
  ri_dq_seq #(.DW(64), .BL(8), .CLW(3)) dut64 (.memclk(clk), .reset_l(reset_l), .bus(bus64.slave));
  ri_dq_seq #(.DW(32), .BL(2), .CLW(3)) dut2  (.memclk(clk), .reset_l(reset_l), .bus(bus2.slave));

  logic [31:0] wexp [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  logic [3:0]  mexp [4] = '{4'h0, 4'hF, 4'h0, 4'h0};
  logic        sexp [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic run_read(input string tag, input logic [2:0] lat, input int L,
                          input logic [127:0] burst);
    bus.cas_lat = lat; bus.cmd_write = 1'b0; bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cas_lat = 3'd6;
    for (int e = 1; e <= L + 3; e++) begin
      bus.dq_in = (e >= L) ? burst[(3 - (e - L)) * 32 +: 32] : 32'hDEADBEEF;
      @(negedge clk);
      chk({tag, "_vld"}, bus.mdin_valid, (e == L + 3));
      chk({tag, "_oe"}, {bus.dq_oe, bus.strobe_oe}, 0);
    end
    chk({tag, "_mdin"}, bus.mdin, burst);
    chk({tag, "_rdy"}, bus.cmd_ready, 1);
    bus.dq_in = '0;
    @(negedge clk);
    chk({tag, "_vld_off"}, bus.mdin_valid, 0);
    chk({tag, "_hold"}, bus.mdin, burst);
  endtask

  initial begin
    logic [127:0] cb;
    logic [511:0] md64, rd64;
    logic [63:0]  mq64;
    int           n_drv;

    bus.cas_lat = '0; bus.cmd_valid = 0; bus.cmd_write = 0; bus.mdout = '0; bus.mdqm = '0; bus.dq_in = '0;
    bus64.cas_lat = '0; bus64.cmd_valid = 0; bus64.cmd_write = 0; bus64.mdout = '0; bus64.mdqm = '0; bus64.dq_in = '0;
    bus2.cas_lat = '0; bus2.cmd_valid = 0; bus2.cmd_write = 0; bus2.mdout = '0; bus2.mdqm = '0; bus2.dq_in = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_rdy", bus.cmd_ready, 1);
    chk("rst_oe", bus.dq_oe, 0);
    chk("rst_soe", bus.strobe_oe, 0);
    chk("rst_so", bus.strobe_out, 0);
    chk("rst_dq", bus.dq_out, 0);
    chk("rst_dqm", bus.dqm_out, 0);
    chk("rst_mdin", bus.mdin, 0);
    chk("rst_vld", bus.mdin_valid, 0);
    chk("rst64_oe", bus64.dq_oe, 0);
    chk("rst2_rdy", bus2.cmd_ready, 1);
    reset_l = 1'b1;
    @(negedge clk);
    chk("rel_rdy", bus.cmd_ready, 1);

    // Write burst, BL=4
    bus.mdout = 128'h11111111_22222222_33333333_44444444;
    bus.mdqm = 16'h0F00; bus.cmd_write = 1'b1; bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("wpre_soe", bus.strobe_oe, 1);
    chk("wpre_so", bus.strobe_out, 0);
    chk("wpre_oe", bus.dq_oe, 0);
    chk("wpre_rdy", bus.cmd_ready, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("wd_dq", bus.dq_out, wexp[k]);
      chk("wd_dqm", bus.dqm_out, mexp[k]);
      chk("wd_oe", bus.dq_oe, 4'hF);
      chk("wd_so", bus.strobe_out, sexp[k]);
      chk("wd_soe", bus.strobe_oe, 1);
    end
    @(negedge clk);
    chk("wpost_soe", bus.strobe_oe, 1);
    chk("wpost_so", bus.strobe_out, 0);
    chk("wpost_oe", bus.dq_oe, 0);
    chk("wpost_rdy", bus.cmd_ready, 0);
    @(negedge clk);
    chk("wend_rdy", bus.cmd_ready, 1);
    chk("wend_soe", bus.strobe_oe, 0);

    // Reset during beat 2 of a read: no pulse, mdin stays at its prior value (0)
    bus.cas_lat = 3'd3; bus.cmd_write = 1'b0; bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    bus.dq_in = 32'hB0B0B0B0;
    @(negedge clk);
    bus.dq_in = 32'hB1B1B1B1;
    @(negedge clk);
    bus.dq_in = 32'hB2B2B2B2;
    reset_l = 1'b0;
    @(negedge clk);
    chk("mrst_vld", bus.mdin_valid, 0);
    chk("mrst_mdin", bus.mdin, 0);
    chk("mrst_rdy", bus.cmd_ready, 1);
    reset_l = 1'b1;
    bus.dq_in = 32'hB3B3B3B3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mrst_novld", bus.mdin_valid, 0);
      chk("mrst_idle", bus.cmd_ready, 1);
    end

    // Reads: cas_lat 3, then cas_lat 0 behaving as 2
    run_read("rd3", 3'd3, 3, 128'hA0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3);
    run_read("rd0", 3'd0, 2, 128'h5EED0000_5EED0001_5EED0002_5EED0003);

    // Back-to-back write then read with cmd_valid held high
    cb = 128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3;
    bus.cas_lat = 3'd2; bus.mdout = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    bus.mdqm = '0; bus.cmd_write = 1'b1; bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_write = 1'b0;
    n_drv = 0;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      if (bus.dq_oe != 0) n_drv++;
    end
    chk("b2b_drv", n_drv, 4);
    chk("b2b_rdy6", bus.cmd_ready, 1);
    chk("b2b_oe6", bus.dq_oe, 0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("b2b_acc", bus.cmd_ready, 0);
    chk("b2b_soe7", bus.strobe_oe, 0);
    for (int e = 8; e <= 12; e++) begin
      bus.dq_in = (e >= 9) ? cb[(3 - (e - 9)) * 32 +: 32] : 32'h0BAD0BAD;
      @(negedge clk);
      chk("b2b_rd_oe", bus.dq_oe, 0);
      chk("b2b_vld", bus.mdin_valid, (e == 12));
    end
    chk("b2b_mdin", bus.mdin, cb);

    // DW=64, BL=8 write
    mq64 = 64'h01020408_10204080;
    for (int k = 0; k < 8; k++) md64[(7 - k) * 64 +: 64] = {8{8'(8'h10 + k)}};
    bus64.mdout = md64; bus64.mdqm = mq64; bus64.cmd_write = 1'b1; bus64.cmd_valid = 1'b1;
    @(negedge clk);
    bus64.cmd_valid = 1'b0;
    chk("w64_pre_oe", bus64.dq_oe, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("w64_dq", bus64.dq_out, {8{8'(8'h10 + k)}});
      chk("w64_dqm", bus64.dqm_out, mq64[(7 - k) * 8 +: 8]);
      chk("w64_oe", bus64.dq_oe, 8'hFF);
      chk("w64_so", bus64.strobe_out, (k % 2 == 0));
    end
    @(negedge clk);
    chk("w64_post", {bus64.strobe_oe, bus64.dq_oe}, 9'h100);
    @(negedge clk);
    chk("w64_rdy", bus64.cmd_ready, 1);

    // DW=64, BL=8 read, cas_lat 4
    for (int k = 0; k < 8; k++) rd64[(7 - k) * 64 +: 64] = {8{8'(8'hA0 + k)}};
    bus64.cas_lat = 3'd4; bus64.cmd_write = 1'b0; bus64.cmd_valid = 1'b1;
    @(negedge clk);
    bus64.cmd_valid = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      bus64.dq_in = (e >= 4) ? {8{8'(8'hA0 + e - 4)}} : 64'h0;
      @(negedge clk);
      chk("r64_vld", bus64.mdin_valid, (e == 11));
    end
    chk("r64_mdin", bus64.mdin, rd64);

    // DW=32, BL=2 write and read
    bus2.mdout = 64'hCAFEF00D_12345678; bus2.mdqm = 8'hA5;
    bus2.cmd_write = 1'b1; bus2.cmd_valid = 1'b1;
    @(negedge clk);
    bus2.cmd_valid = 1'b0;
    @(negedge clk);
    chk("w2_dq0", bus2.dq_out, 32'hCAFEF00D);
    chk("w2_dqm0", bus2.dqm_out, 4'hA);
    chk("w2_so0", bus2.strobe_out, 1);
    chk("w2_oe0", bus2.dq_oe, 4'hF);
    @(negedge clk);
    chk("w2_dq1", bus2.dq_out, 32'h12345678);
    chk("w2_dqm1", bus2.dqm_out, 4'h5);
    chk("w2_so1", bus2.strobe_out, 0);
    @(negedge clk);
    chk("w2_post", {bus2.strobe_oe, bus2.dq_oe, bus2.cmd_ready}, 6'b100000);
    @(negedge clk);
    chk("w2_rdy", bus2.cmd_ready, 1);
    bus2.cas_lat = 3'd2; bus2.cmd_write = 1'b0; bus2.cmd_valid = 1'b1;
    @(negedge clk);
    bus2.cmd_valid = 1'b0;
    bus2.dq_in = 32'hFFFF0000;
    @(negedge clk);
    chk("r2_vld1", bus2.mdin_valid, 0);
    bus2.dq_in = 32'h5A5A0001;
    @(negedge clk);
    chk("r2_vld2", bus2.mdin_valid, 0);
    bus2.dq_in = 32'h5A5A0002;
    @(negedge clk);
    chk("r2_vld3", bus2.mdin_valid, 1);
    chk("r2_mdin", bus2.mdin, 64'h5A5A0001_5A5A0002);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ri_dq_seq.md
# ri_dq_seq

Parametrised single-clock successor to the RI pad data path. It serialises one full write burst (data plus byte masks) onto a DW-wide pad bus, with per-lane output enables and a strobe preamble/postamble. It captures one read burst after a programmable CAS latency and presents it as a single wide word. It sits between the RI controller and the DDR conversion pad cells, which run at the pad edge rates.

## Interface
- DW, 32, pad data width in bits; multiple of 8
- BL, 4, beats per burst; 2, 4 or 8
- CLW, 3, width of the CAS-latency field
- LANES (derived), DW/8, number of byte lanes
---
- memclk  in  1  sole clock; all state updates on posedge
- reset_l  in  1  synchronous, active-low reset
- cas_lat  in  CLW  read latency in cycles; quasi-static; values below 2 are treated as 2
- cmd_valid  in  1  command request
- cmd_write  in  1  1 = write, 0 = read; qualified by cmd_valid
- cmd_ready  out  1  block idle, command will be accepted
- mdout  in  BL*DW  write burst; beat 0 = MSB slice; sampled at accept
- mdqm  in  BL*LANES  write byte masks (1 = masked); beat 0 = MSB slice; sampled at accept
- mdin  out  BL*DW  assembled read burst; beat 0 = MSB slice
- mdin_valid  out  1  one-cycle pulse when mdin is updated
- dq_out  out  DW  pad write data
- dq_oe  out  LANES  per-byte-lane output enable
- dq_in  in  DW  pad read data, already single-rate
- dqm_out  out  LANES  pad byte mask
- strobe_out  out  1  pad strobe value
- strobe_oe  out  1  pad strobe output enable

## Operation
- States:
  - IDLE: cmd_ready = 1.
  - WPRE: write preamble.
  - WDATA: BL write data beats.
  - WPOST: write postamble.
  - RWAIT: waiting out the CAS latency.
  - RCAP: capturing BL read beats.
- Transitions:
  - Accept = cmd_valid & cmd_ready at a posedge; mdout and mdqm are latched there.
  - IDLE→WPRE (write) or IDLE→RWAIT (read).
  - WPRE→WDATA after 1 cycle; WDATA→WPOST after BL cycles; WPOST→IDLE after 1 cycle.
  - RWAIT→RCAP after cas_lat−1 cycles; RCAP→IDLE after BL cycles.
- Beat counter: log2(BL) bits. Latency counter: CLW bits, loaded at accept. Neither counter wraps inside a burst.
- WPRE: strobe_oe = 1, strobe_out = 0, dq_oe = 0.
- WDATA beat k:
  - dq_oe = all ones; dq_out = beat k; dqm_out = mask k.
  - strobe_out = 1 for even k, 0 for odd k.
- WPOST: strobe_oe = 1, strobe_out = 0, dq_oe = 0.
- Read states: dq_oe = 0, strobe_oe = 0, dqm_out = 0.
- Read assembly: beat k of dq_in is shifted into the capture register. mdin is loaded from that register together with the final beat; mdin_valid pulses for that one cycle. mdin then holds until the next read completes.
- Commands presented while cmd_ready = 0 are ignored, not queued.
- cas_lat changes are sampled at read accept only.

## Timing
- All outputs are registered.
- Reset values: cmd_ready = 1 (from the cycle after reset), dq_oe = 0, strobe_oe = 0, strobe_out = 0, dq_out = 0, dqm_out = 0, mdin = 0, mdin_valid = 0, state IDLE.
- Write accepted at edge E0:
  - WPRE is visible after E0.
  - Beat k is visible after E(1+k).
  - WPOST is visible after E(BL+1).
  - cmd_ready = 1 after E(BL+2); next accept is possible at E(BL+3).
- Read accepted at edge E0:
  - dq_in beat k is sampled at E(L+k), where L = max(cas_lat, 2).
  - mdin and mdin_valid are updated at E(L+BL−1).
  - cmd_ready = 1 from that same edge; next accept is possible at E(L+BL).
- Bus turnaround is guaranteed: at least one non-driving cycle (WPOST) after every write, and dq_oe is never set during reads.
- Reset mid-burst: at the next edge all enables go to 0, the state returns to IDLE, and any partial read is discarded (no mdin_valid pulse).

## Structure
- Package ri_pkg holds:
  - the state enum
  - legal BL values and an elaboration-time check (DW % 8 == 0, BL ∈ {2, 4, 8})
  - the LANES and log2(BL) helper functions
- One sub-module, ri_burst_shift: a parametrised BL×W shift register with load and shift. It is instanced three times: write data, write masks, read capture.

## Test plan
- Reset values: assert reset_l = 0 for 3 cycles, release → all outputs at their reset values; cmd_ready = 1.
- Write burst (DW = 32, BL = 4): mdout = 0x11111111_22222222_33333333_44444444, mdqm = 0x0F00 → beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 after E1..E4; dqm_out 0, F, 0, 0; strobe 1, 0, 1, 0; preamble and postamble have strobe_oe = 1 with dq_oe = 0; cmd_ready returns after E6.
- Read burst, cas_lat = 3: dq_in = A0..A3 at E3..E6 → mdin = A0A1A2A3 with mdin_valid after E6 only; cas_lat = 0 behaves as 2.
- Back-to-back write then read with cmd_valid held high → read accepted at E7; dq_oe = 0 for ≥1 cycle before the read window.
- Reset at beat 2 of a read → no mdin_valid pulse; mdin unchanged; IDLE next cycle.
- Parameter sweep BL = 2/8, DW = 64 → per-lane dq_oe width = 8; beat ordering MSB-first.
